// File: rtl/mesh_pkg.sv
// Shared types and sizing helpers for the mesh shearsort controller and its PEs.
package mesh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int SQRT_N_DEF      = 4;
    localparam int LOG_SQRT_N_DEF  = 2;
    localparam int STEP_CYCLES_DEF = 1;

    // Shearsort needs log2(sqrt_n) row/column pairs plus one closing row phase.
    function automatic int num_phases(input int log_sqrt_n);
        return 2 * log_sqrt_n + 1;
    endfunction

    // Cycles from start to the done pulse inclusive; the PEs size their sort window with this.
    function automatic int sort_len(input int sqrt_n, input int log_sqrt_n, input int step_cycles);
        return num_phases(log_sqrt_n) * sqrt_n * step_cycles + 1;
    endfunction

    localparam int NUM_PHASES = num_phases(LOG_SQRT_N_DEF);
    localparam int SORT_LEN   = NUM_PHASES * SQRT_N_DEF * STEP_CYCLES_DEF + 1;

endpackage

// File: rtl/mesh_sort_sequencer_if.sv
// Start/status and compare-exchange strobe bundle between a requester and the sequencer.
interface mesh_sort_sequencer_if #(
    parameter int LOG_SQRT_N = 2
);
    localparam int PW = $clog2(2 * LOG_SQRT_N + 1);

    logic          start;
    logic          busy;
    logic          done;
    logic          cmp_en;
    logic          phase_col;
    logic          step_odd;
    logic [PW-1:0] phase_idx;

    modport master (
        output start,
        input  busy, done, cmp_en, phase_col, step_odd, phase_idx
    );

    modport slave (
        input  start,
        output busy, done, cmp_en, phase_col, step_odd, phase_idx
    );

endinterface

// File: rtl/mesh_sort_sequencer_mod_counter.sv
// Modulo-MOD up-counter; wrap flags the enabled cycle on which it returns to zero,
// so several instances chain into a mixed-radix counter.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = en && (q == W'(MOD - 1));

    // Count on enable, return to zero at the terminal value, clear has priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/mesh_sort_sequencer.sv
// Shearsort phase/step sequencer: broadcasts compare-exchange strobes to the mesh PEs.
//
//   state | meaning
//   IDLE  | waiting for start, counters held at zero
//   RUN   | stepping sub-cycle -> step -> phase counters, strobing cmp_en
//   DONE  | one-cycle done pulse, then back to IDLE regardless of start
module mesh_sort_sequencer
    import mesh_pkg::*;
#(
    parameter int SQRT_N      = 4,
    parameter int LOG_SQRT_N  = 2,
    parameter int STEP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mesh_sort_sequencer_if.slave  bus
);

    localparam int PHASES = num_phases(LOG_SQRT_N);
    localparam int PW     = $clog2(PHASES);
    localparam int SW     = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
    localparam int CW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic          run;
    logic          cnt_clr;
    logic [CW-1:0] sub_q;
    logic [SW-1:0] step_q;
    logic [PW-1:0] phase_q;
    logic          sub_wrap;
    logic          step_wrap;
    logic          phase_wrap;

    assign run     = (state == RUN);
    assign cnt_clr = !run;

    mod_counter #(.MOD(STEP_CYCLES), .W(CW)) u_sub_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (run),
        .q    (sub_q),
        .wrap (sub_wrap)
    );

    mod_counter #(.MOD(SQRT_N), .W(SW)) u_step_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (sub_wrap),
        .q    (step_q),
        .wrap (step_wrap)
    );

    mod_counter #(.MOD(PHASES), .W(PW)) u_phase_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (step_wrap),
        .q    (phase_q),
        .wrap (phase_wrap)
    );

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, and output decode from registered state/counters only.
    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.cmp_en    = 1'b0;
        bus.phase_col = 1'b0;
        bus.step_odd  = 1'b0;
        bus.phase_idx = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                bus.busy      = 1'b1;
                bus.cmp_en    = (sub_q == '0);
                bus.phase_col = phase_q[0];
                bus.step_odd  = ((step_q & SW'(1)) != '0);
                bus.phase_idx = phase_q;
                if (phase_wrap) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mesh_sort_sequencer.md
# mesh_sort_sequencer

Central control FSM for the shearsort routing phase of the `mesh` array. It emits the per-step compare-exchange strobes: row/column phase select and odd/even step parity, broadcast to all PEs. Row phases alternate with column phases, and the sequence ends on a row phase. With default parameters one full sort takes exactly `SORT_CYCLES` = 21 cycles from `start` to `done`, so the PEs' fixed sort window is driven by an explicit controller.

## Interface
- `SQRT_N`, 4: mesh side length; power of two, ≥2.
- `LOG_SQRT_N`, 2: log2(`SQRT_N`).
- `STEP_CYCLES`, 1: cycles per compare-exchange step, ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  request a sort; sampled only in IDLE.
- `busy`  out  1  sort in progress.
- `done`  out  1  one-cycle pulse after the final step.
- `cmp_en`  out  1  PEs perform one compare-exchange this cycle.
- `phase_col`  out  1  0 = row phase (snake order: even rows ascending, odd rows descending); 1 = column phase (ascending).
- `step_odd`  out  1  0 = even pairs (0-1, 2-3…); 1 = odd pairs (1-2, 3-4…).
- `phase_idx`  out  clog2(2·`LOG_SQRT_N`+1)  current phase number, 0-based.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1. The step, sub-cycle and phase counters load 0.
- RUN structure:
  - `phase_idx` counts 0 … 2·`LOG_SQRT_N`.
  - Even `phase_idx` is a row phase; odd is a column phase (`phase_col` = `phase_idx[0]`).
  - Each phase has `SQRT_N` steps (odd-even transposition). `step_odd` = step index bit 0.
  - Each step lasts `STEP_CYCLES` cycles. `cmp_en` = 1 only in the first cycle of each step.
- Advancing:
  - Sub-cycle counter wraps at `STEP_CYCLES`−1, then the step index increments.
  - Step index wraps at `SQRT_N`−1, then `phase_idx` increments.
  - Wrap of the last step of phase 2·`LOG_SQRT_N` → DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then unconditionally → IDLE. `start` is ignored in DONE.
- `start` during RUN: ignored; does not restart.
- Reset values (`rst`=0 at an edge, from any state, including mid-RUN): state IDLE, all counters 0.
  - Outputs: `busy`=0, `done`=0, `cmp_en`=0, `phase_col`=0, `step_odd`=0, `phase_idx`=0.
  - No partial-sort completion; `done` is never asserted for an aborted run.
- All outputs are registered, or decoded from registered state only. No combinational path from `start` to any output.
- Outside RUN: `cmp_en`, `phase_col`, `step_odd` = 0; `phase_idx` holds 0.

## Timing
- Cycle 0: `start`=1 sampled in IDLE.
- Cycle 1: `busy`=1, `cmp_en`=1, `phase_col`=0, `step_odd`=0, `phase_idx`=0.
- Total RUN length = (2·`LOG_SQRT_N`+1)·`SQRT_N`·`STEP_CYCLES` cycles.
  - Defaults: 5·4·1 = 20 cycles (cycles 1–20), `cmp_en` high on every one.
- Default phase order: rows (cycles 1–4), cols (5–8), rows (9–12), cols (13–16), rows (17–20). `step_odd` toggles 0,1,0,1 within each phase.
- Cycle RUN+1 (21 by default): `done`=1, `busy`=0.
- Next cycle: IDLE. Earliest accepted restart is `start` sampled in that cycle, giving a new RUN on the following cycle.
- `start` held high continuously: back-to-back sorts with period RUN+2 cycles (22 by default).

## Structure
- Shared package `mesh_pkg`:
  - state enum (IDLE/RUN/DONE);
  - localparams `NUM_PHASES` = 2·`LOG_SQRT_N`+1 and `SORT_LEN` = `NUM_PHASES`·`SQRT_N`·`STEP_CYCLES`+1.
  - `mesh` and its PEs reuse `SORT_LEN` in place of a hand-set `SORT_CYCLES`.
- One sub-module: `mod_counter`.
  - Ports: parameterised modulus, `clr`, `en`, `q`, `wrap`.
  - Instantiated three times, chained via `wrap`: sub-cycle, step, phase.
- FSM and output decode live in `mesh_sort_sequencer`.

## Test plan
- Defaults; `rst`=0 for 2 cycles, then 1; `start` pulse at cycle 0 → `busy` high cycles 1–20; `cmp_en` high 20 cycles; `done` high only at cycle 21; all outputs 0 during reset.
- Same run; log (`phase_col`, `step_odd`) per cycle → `phase_col` sequence 0×4,1×4,0×4,1×4,0×4; `step_odd` 0,1,0,1 repeating; `phase_idx` 0…4.
- `STEP_CYCLES`=3 → `cmp_en` high every third cycle starting cycle 1 (20 pulses); `done` at cycle 61.
- `start` re-asserted at cycles 5 and 21 → no restart, no second `busy` window; `start` held high → second RUN begins at cycle 23.
- `rst`=0 at cycle 10 mid-RUN → next cycle all outputs 0, no `done` pulse; new `start` afterwards produces a full 20-step RUN.
- `SQRT_N`=8, `LOG_SQRT_N`=3 → RUN 56 cycles, `phase_idx` reaches 6, last phase row (`phase_col`=0), `done` at cycle 57.
